// File: rtl/arb_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arb_mux_pkg
// Description : Shared types and constants for the arb_mux stream arbiter:
//               FSM state encoding and arbitration mode encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package arb_mux_pkg;

    // Two-state packet FSM: IDLE arbitrates, LOCKED streams one packet
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // Arbitration mode as presented on the mode input
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

endpackage : arb_mux_pkg
`default_nettype wire

// File: rtl/arb_mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational rotating-priority pick. The search starts at
//               pointer+1 and wraps modulo NUMIN, so the channel named by
//               pointer has lowest priority. Works for any NUMIN >= 2.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUMIN  = 16,
    parameter int SWIDTH = $clog2(NUMIN)
) (
    input  logic [NUMIN-1:0]  req,
    input  logic [SWIDTH-1:0] pointer,
    output logic [SWIDTH-1:0] gnt_idx,
    output logic              gnt_any
);

    // One extra bit so pointer + offset never overflows before the wrap
    localparam logic [SWIDTH:0] c_NUMIN_W = (SWIDTH+1)'(NUMIN);

    logic [SWIDTH:0] w_cand;

    // Walk offsets 1..NUMIN from the pointer; first requesting channel wins
    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        w_cand  = '0;
        for (int k = 1; k <= NUMIN; k++) begin
            w_cand = {1'b0, pointer} + (SWIDTH+1)'(k);
            if (w_cand >= c_NUMIN_W) begin
                w_cand = w_cand - c_NUMIN_W;
            end
            if (!gnt_any && req[w_cand[SWIDTH-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = w_cand[SWIDTH-1:0];
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/arb_mux.sv
`default_nettype none
// ============================================================================
// Module      : arb_mux
// Description : NUMIN:1 stream mux with per-channel valid/ready, packet
//               locking on the last flag, fixed-select or round-robin
//               arbitration, and a single registered output stage with
//               backpressure.
//               Optional: define ARB_MUX_STATS_EN to add per-channel 16-bit
//               packet counters on output port pkt_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_mux
    import arb_mux_pkg::*;
#(
    parameter int NUMIN  = 16,
    parameter int DWIDTH = 14,
    parameter int SWIDTH = $clog2(NUMIN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mode,
    input  logic [SWIDTH-1:0]       sel,
    input  logic [NUMIN*DWIDTH-1:0] din_vec,
    input  logic [NUMIN-1:0]        din_vec_v,
    input  logic [NUMIN-1:0]        din_vec_last,
    output logic [NUMIN-1:0]        din_vec_rdy,
    output logic [DWIDTH-1:0]       dout,
    output logic                    dout_v,
    output logic                    dout_last,
    input  logic                    dout_rdy,
    output logic [SWIDTH-1:0]       grant
`ifdef ARB_MUX_STATS_EN
    ,
    output logic [16*NUMIN-1:0]     pkt_cnt
`endif
);

    localparam logic [SWIDTH:0]   c_NUMIN_W = (SWIDTH+1)'(NUMIN);
    localparam logic [SWIDTH-1:0] c_PTR_RST = SWIDTH'(NUMIN-1);

    state_t             r_state_q;
    logic [SWIDTH-1:0]  r_grant_q;
    logic [SWIDTH-1:0]  r_ptr_q;
    logic [DWIDTH-1:0]  r_dout_q;
    logic               r_dout_v_q;
    logic               r_dout_last_q;

    logic [DWIDTH-1:0]  w_ch_data [NUMIN];
    logic [DWIDTH-1:0]  w_grant_data;
    logic               w_grant_v;
    logic               w_grant_last;
    logic               w_locked;
    logic               w_out_free;
    logic               w_accept;
    logic               w_sel_v;
    logic [SWIDTH-1:0]  w_rr_idx;
    logic               w_rr_any;
    logic [NUMIN-1:0]   w_rdy;

    // Split the flat input bus into per-channel words
    generate
        for (genvar gi = 0; gi < NUMIN; gi++) begin : g_unpack
            assign w_ch_data[gi] = din_vec[gi*DWIDTH +: DWIDTH];
        end
    endgenerate

    assign w_grant_data = w_ch_data[r_grant_q];
    assign w_grant_v    = din_vec_v[r_grant_q];
    assign w_grant_last = din_vec_last[r_grant_q];
    assign w_locked     = (r_state_q == ST_LOCKED);

    // Output register can take a beat if empty or being drained this cycle
    assign w_out_free   = !r_dout_v_q || dout_rdy;
    assign w_accept     = w_locked && w_grant_v && w_out_free;

    // An out-of-range select is never granted
    assign w_sel_v      = ({1'b0, sel} < c_NUMIN_W) && din_vec_v[sel];

    rr_arbiter #(
        .NUMIN   (NUMIN),
        .SWIDTH  (SWIDTH)
    ) u_rr_arbiter (
        .req     (din_vec_v),
        .pointer (r_ptr_q),
        .gnt_idx (w_rr_idx),
        .gnt_any (w_rr_any)
    );

    // Ready goes only to the locked channel; IDLE costs one arbitration cycle
    always_comb begin
        w_rdy = '0;
        if (w_locked && w_out_free) begin
            w_rdy[r_grant_q] = 1'b1;
        end
    end

    assign din_vec_rdy = w_rdy;

    // Packet FSM plus registered output stage
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= ST_IDLE;
            r_grant_q     <= '0;
            r_ptr_q       <= c_PTR_RST;
            r_dout_q      <= '0;
            r_dout_v_q    <= 1'b0;
            r_dout_last_q <= 1'b0;
        end else begin
            // Accept overrides drain so back-to-back beats have no bubble
            if (w_accept) begin
                r_dout_q      <= w_grant_data;
                r_dout_last_q <= w_grant_last;
                r_dout_v_q    <= 1'b1;
            end else if (r_dout_v_q && dout_rdy) begin
                r_dout_v_q    <= 1'b0;
            end

            case (r_state_q)
                ST_IDLE: begin
                    if (mode == MODE_FIXED) begin
                        if (w_sel_v) begin
                            r_grant_q <= sel;
                            r_state_q <= ST_LOCKED;
                        end
                    end else if (w_rr_any) begin
                        r_grant_q <= w_rr_idx;
                        r_state_q <= ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    // Pointer records the finished channel so it drops to lowest priority
                    if (w_accept && w_grant_last) begin
                        r_ptr_q   <= r_grant_q;
                        r_state_q <= ST_IDLE;
                    end
                end
                default: begin
                    r_state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign dout      = r_dout_q;
    assign dout_v    = r_dout_v_q;
    assign dout_last = r_dout_last_q;
    assign grant     = r_grant_q;

`ifdef ARB_MUX_STATS_EN
    generate
        for (genvar gc = 0; gc < NUMIN; gc++) begin : g_stats
            logic [15:0] r_cnt_q;

            // Count completed packets per channel; wraps naturally at 0xFFFF
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt_q <= '0;
                end else if (w_accept && w_grant_last && (r_grant_q == SWIDTH'(gc))) begin
                    r_cnt_q <= r_cnt_q + 16'd1;
                end
            end

            assign pkt_cnt[gc*16 +: 16] = r_cnt_q;
        end
    endgenerate
`endif

endmodule : arb_mux
`default_nettype wire

// File: tb/tb_arb_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_arb_mux
// Description : Directed self-checking bench for arb_mux (16 x 14-bit).
//               Covers reset, fixed select, round-robin order, packet lock,
//               backpressure, mid-packet reset and, when ARB_MUX_STATS_EN is
//               defined, the packet counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arb_mux;

    localparam int NUMIN  = 16;
    localparam int DWIDTH = 14;
    localparam int SWIDTH = 4;

    logic                    clk;
    logic                    rst;
    logic                    mode;
    logic [SWIDTH-1:0]       sel;
    logic [NUMIN*DWIDTH-1:0] din_vec;
    logic [NUMIN-1:0]        din_vec_v;
    logic [NUMIN-1:0]        din_vec_last;
    logic [NUMIN-1:0]        din_vec_rdy;
    logic [DWIDTH-1:0]       dout;
    logic                    dout_v;
    logic                    dout_last;
    logic                    dout_rdy;
    logic [SWIDTH-1:0]       grant;
`ifdef ARB_MUX_STATS_EN
    logic [16*NUMIN-1:0]     pkt_cnt;
`endif

    int checks = 0;
    int errors = 0;

    arb_mux #(
        .NUMIN        (NUMIN),
        .DWIDTH       (DWIDTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mode         (mode),
        .sel          (sel),
        .din_vec      (din_vec),
        .din_vec_v    (din_vec_v),
        .din_vec_last (din_vec_last),
        .din_vec_rdy  (din_vec_rdy),
        .dout         (dout),
        .dout_v       (dout_v),
        .dout_last    (dout_last),
        .dout_rdy     (dout_rdy),
        .grant        (grant)
`ifdef ARB_MUX_STATS_EN
        ,
        .pkt_cnt      (pkt_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int ch, input logic [DWIDTH-1:0] d, input logic v, input logic l);
        din_vec[ch*DWIDTH +: DWIDTH] = d;
        din_vec_v[ch]                = v;
        din_vec_last[ch]             = l;
    endtask

    initial begin
        rst          = 1'b1;
        mode         = 1'b0;
        sel          = '0;
        din_vec      = '0;
        din_vec_v    = '0;
        din_vec_last = '0;
        dout_rdy     = 1'b1;

        // ---------------- reset state ----------------
        tick();
        tick();
        chk("rst_dout_v", 32'(dout_v), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_dout_last", 32'(dout_last), 32'd0);
        chk("rst_rdy", 32'(din_vec_rdy), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        rst = 1'b0;

        // ---------------- fixed select, ch5, 3 beats ----------------
        mode = 1'b0;
        sel  = 4'd5;
        set_ch(5, 14'h0A1, 1'b1, 1'b0);
        tick();
        chk("fx_grant", 32'(grant), 32'd5);
        chk("fx_idle_dout_v", 32'(dout_v), 32'd0);
        chk("fx_rdy", 32'(din_vec_rdy), 32'h0020);
        tick();
        chk("fx_b1_data", 32'(dout), 32'h0A1);
        chk("fx_b1_v", 32'(dout_v), 32'd1);
        chk("fx_b1_last", 32'(dout_last), 32'd0);
        set_ch(5, 14'h0A2, 1'b1, 1'b0);
        tick();
        chk("fx_b2_data", 32'(dout), 32'h0A2);
        chk("fx_b2_rdy", 32'(din_vec_rdy), 32'h0020);
        set_ch(5, 14'h0A3, 1'b1, 1'b1);
        tick();
        chk("fx_b3_data", 32'(dout), 32'h0A3);
        chk("fx_b3_last", 32'(dout_last), 32'd1);
        chk("fx_b3_grant", 32'(grant), 32'd5);
        chk("fx_after_rdy", 32'(din_vec_rdy), 32'd0);
        set_ch(5, 14'h0A3, 1'b0, 1'b0);
        tick();
        chk("fx_drain_v", 32'(dout_v), 32'd0);
        chk("fx_drain_hold", 32'(dout), 32'h0A3);

        // ---------------- round robin, all 16 single-beat ----------------
        rst = 1'b1;
        tick();
        rst  = 1'b0;
        mode = 1'b1;
        for (int i = 0; i < NUMIN; i++) begin
            set_ch(i, DWIDTH'(i), 1'b1, 1'b1);
        end
        for (int k = 0; k <= NUMIN; k++) begin
            tick();
            chk("rr_grant", 32'(grant), 32'(k % NUMIN));
            tick();
            chk("rr_dout", 32'(dout), 32'(k % NUMIN));
            chk("rr_last", 32'(dout_last), 32'd1);
        end
        din_vec_v    = '0;
        din_vec_last = '0;
        tick();

        // ---------------- round robin packet lock ----------------
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_ch(3, 14'h030, 1'b1, 1'b0);
        tick();
        chk("lk_grant3", 32'(grant), 32'd3);
        tick();
        chk("lk_b1", 32'(dout), 32'h030);
        set_ch(3, 14'h031, 1'b1, 1'b0);
        tick();
        chk("lk_b2", 32'(dout), 32'h031);
        set_ch(1, 14'h011, 1'b1, 1'b1);
        set_ch(3, 14'h032, 1'b1, 1'b0);
        #1;
        chk("lk_rdy_only3", 32'(din_vec_rdy), 32'h0008);
        tick();
        chk("lk_b3", 32'(dout), 32'h032);
        chk("lk_b3_grant", 32'(grant), 32'd3);
        set_ch(3, 14'h033, 1'b1, 1'b1);
        tick();
        chk("lk_b4", 32'(dout), 32'h033);
        chk("lk_b4_last", 32'(dout_last), 32'd1);
        set_ch(3, 14'h000, 1'b0, 1'b0);
        set_ch(9, 14'h099, 1'b1, 1'b1);
        tick();
        chk("lk_grant9", 32'(grant), 32'd9);
        tick();
        chk("lk_dout9", 32'(dout), 32'h099);
        set_ch(9, 14'h000, 1'b0, 1'b0);
        tick();
        chk("lk_grant1_wrap", 32'(grant), 32'd1);
        tick();
        chk("lk_dout1", 32'(dout), 32'h011);
        set_ch(1, 14'h000, 1'b0, 1'b0);
        tick();

        // ---------------- backpressure ----------------
        mode = 1'b0;
        sel  = 4'd2;
        set_ch(2, 14'h021, 1'b1, 1'b0);
        tick();
        chk("bp_grant", 32'(grant), 32'd2);
        tick();
        chk("bp_b1", 32'(dout), 32'h021);
        set_ch(2, 14'h022, 1'b1, 1'b0);
        tick();
        chk("bp_b2", 32'(dout), 32'h022);
        set_ch(2, 14'h023, 1'b1, 1'b0);
        dout_rdy = 1'b0;
        #1;
        chk("bp_rdy_low", 32'(din_vec_rdy), 32'd0);
        for (int s = 0; s < 5; s++) begin
            tick();
            chk("bp_hold_data", 32'(dout), 32'h022);
            chk("bp_hold_v", 32'(dout_v), 32'd1);
            chk("bp_hold_rdy", 32'(din_vec_rdy), 32'd0);
        end
        dout_rdy = 1'b1;
        #1;
        chk("bp_rdy_back", 32'(din_vec_rdy), 32'h0004);
        tick();
        chk("bp_b3", 32'(dout), 32'h023);
        set_ch(2, 14'h024, 1'b1, 1'b1);
        tick();
        chk("bp_b4", 32'(dout), 32'h024);
        chk("bp_b4_last", 32'(dout_last), 32'd1);
        set_ch(2, 14'h000, 1'b0, 1'b0);
        tick();
        chk("bp_drain_v", 32'(dout_v), 32'd0);

        // ---------------- reset mid-packet ----------------
        mode = 1'b1;
        set_ch(6, 14'h061, 1'b1, 1'b0);
        tick();
        chk("mr_grant6", 32'(grant), 32'd6);
        tick();
        chk("mr_b1", 32'(dout), 32'h061);
        set_ch(6, 14'h062, 1'b1, 1'b0);
        set_ch(0, 14'h005, 1'b1, 1'b1);
        rst = 1'b1;
        tick();
        chk("mr_rst_v", 32'(dout_v), 32'd0);
        chk("mr_rst_grant", 32'(grant), 32'd0);
        chk("mr_rst_rdy", 32'(din_vec_rdy), 32'd0);
        rst = 1'b0;
        tick();
        chk("mr_grant0", 32'(grant), 32'd0);
        tick();
        chk("mr_dout0", 32'(dout), 32'h005);
        din_vec_v    = '0;
        din_vec_last = '0;
        tick();

`ifdef ARB_MUX_STATS_EN
        // ---------------- packet counters ----------------
        rst = 1'b1;
        tick();
        rst  = 1'b0;
        mode = 1'b0;
        sel  = 4'd2;
        set_ch(2, 14'h002, 1'b1, 1'b1);
        for (int p = 0; p < 6; p++) begin
            tick();
        end
        set_ch(2, 14'h000, 1'b0, 1'b0);
        sel = 4'd7;
        set_ch(7, 14'h007, 1'b1, 1'b1);
        tick();
        tick();
        set_ch(7, 14'h000, 1'b0, 1'b0);
        tick();
        chk("st_cnt2", 32'(pkt_cnt[2*16 +: 16]), 32'd3);
        chk("st_cnt7", 32'(pkt_cnt[7*16 +: 16]), 32'd1);
        chk("st_cnt0", 32'(pkt_cnt[0 +: 16]), 32'd0);
        chk("st_cnt5", 32'(pkt_cnt[5*16 +: 16]), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_arb_mux
`default_nettype wire

// File: doc/arb_mux.md
Name: arb_mux

Overview:
- Parametrised successor to the team's registered N:1 mux.
- Adds a per-channel valid/ready handshake, packet locking via a last flag, and a selectable arbitration mode: fixed select or round-robin.
- Output is a single registered stage with backpressure.
- Sits between multiple stream producers (e.g. ADC channel formatters) and one shared downstream consumer.

Parameters:
- NUMIN, 16, number of input channels (>=2).
- DWIDTH, 14, data width per channel.
- SWIDTH, $clog2(NUMIN), select/grant width (derived, do not override).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- mode  in  1  0 = fixed select via sel; 1 = round-robin arbitration.
- sel  in  SWIDTH  channel select used when mode=0; sampled only in IDLE.
- din_vec  in  NUMIN*DWIDTH  channel i data at [i*DWIDTH +: DWIDTH].
- din_vec_v  in  NUMIN  per-channel valid.
- din_vec_last  in  NUMIN  per-channel end-of-packet flag, qualified by valid.
- din_vec_rdy  out  NUMIN  per-channel ready; at most one bit set.
- dout  out  DWIDTH  registered output data.
- dout_v  out  1  output valid.
- dout_last  out  1  output end-of-packet.
- dout_rdy  in  1  downstream ready.
- grant  out  SWIDTH  currently/last granted channel.

Behaviour:
- Reset (synchronous, rst=1 at posedge clk):
  - dout=0, dout_v=0, dout_last=0, din_vec_rdy=0, grant=0, state=IDLE.
  - Round-robin pointer = NUMIN-1, so channel 0 has first priority.
- Transfer rules:
  - Input beat transfers when din_vec_v[i] & din_vec_rdy[i] at posedge clk.
  - Output beat transfers when dout_v & dout_rdy.
- States: IDLE, LOCKED.
- IDLE:
  - mode=0: if din_vec_v[sel], set grant=sel and go to LOCKED; else stay in IDLE.
  - mode=1: search channels starting at pointer+1, wrapping modulo NUMIN. The first valid channel becomes grant and the FSM goes to LOCKED. If no channel is valid, stay in IDLE.
  - din_vec_rdy=0 in IDLE, which costs one arbitration cycle per packet.
- LOCKED:
  - din_vec_rdy[grant] = !dout_v | dout_rdy (pass-through with backpressure); all other rdy bits are 0.
  - On an accepted beat: dout <= din_vec[grant], dout_last <= din_vec_last[grant], dout_v <= 1.
  - On an accepted beat with last=1: go to IDLE and set pointer <= grant.
- If an output beat is consumed with no new input beat accepted: dout_v <= 0. dout holds its last value.
- Latency: 1 clk from input accept to dout_v.
- Throughput: 1 beat/clk within a packet.
- Packet lock: mode and sel changes are ignored while LOCKED and take effect at the next IDLE.
- Simultaneous output consume and input accept: dout_v stays 1 and the data updates (no bubble).
- dout_rdy=0 with dout_v=1: dout, dout_v and dout_last hold; din_vec_rdy[grant]=0.
- Single-beat packet (last on the first beat): returns to IDLE after one beat.
- NUMIN not a power of two: pointer and sel wrap at NUMIN-1. A sel >= NUMIN in mode 0 is never granted and the FSM stays in IDLE.
- Reset mid-packet: returns to IDLE and drops the in-flight output beat; no partial recovery.

Optional Feature:
- ARB_MUX_STATS_EN defined:
  - Adds output port pkt_cnt [16*NUMIN-1:0].
  - Per-channel 16-bit counter, incremented on each accepted beat with last=1 for that channel.
  - Counters wrap at 0xFFFF and clear on rst.
- ARB_MUX_STATS_EN undefined: port and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package arb_mux_pkg holds:
  - state encoding constants ST_IDLE=1'b0, ST_LOCKED=1'b1;
  - mode constants MODE_FIXED=0, MODE_RR=1.
- Sub-module rr_arbiter (NUMIN): combinational rotating-priority pick.
  - Inputs: req, pointer.
  - Outputs: gnt_idx, gnt_any.
  - Instantiated once; reusable elsewhere.

Test Plan:
- Fixed mode, sel=5, ch5 sends 3 beats 0x0A1,0x0A2,0x0A3 with last on the third, dout_rdy=1 -> dout shows 0x0A1..0x0A3 on consecutive cycles with 1-clk latency, dout_last on 0x0A3, grant=5, other rdy bits 0.
- RR mode, all 16 channels valid with 1-beat packets (data=channel index) -> grant order 0,1,2,...,15,0; every dout equals grant.
- RR mode, ch3 mid-packet (2 of 4 beats sent), ch1 raises valid -> ch3 completes all 4 beats before ch1 is granted; ch1 is next after wrap only if no channel in 4..15 is valid.
- Backpressure: dout_rdy low for 5 cycles mid-packet -> dout/dout_v stable, din_vec_rdy[grant]=0, no beat lost or duplicated; full sequence resumes when dout_rdy returns high.
- Reset asserted during LOCKED beat 2 -> next cycle dout_v=0, din_vec_rdy=0, grant=0; after release, RR first grants ch0 if it is valid.
- With ARB_MUX_STATS_EN: 3 packets on ch2 and 1 on ch7 -> pkt_cnt[2]=3, pkt_cnt[7]=1, others 0.
